alu_operand_sequencer: RTL

Multi-cycle operand/result stage wrapped around the 32-bit ALU. It captures operand A (Y register) and operand B from the shared 32-bit bus on successive cycles. It drives the ALU opcode and operands, holds them for a programmable settle time, then captures the 64-bit Z result. It writes Z back as LO, or as LO then HI for MUL/DIV, through a valid/ready handshake.

---
 rtl/alu_pkg.sv | 47 ++++
 rtl/seq_exec_counter.sv | 27 ++
 rtl/alu_operand_sequencer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcodes, sequencer state encoding and opcode classification helpers shared by
// the ALU operand/result sequencer.
package alu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_SHR  = 5'b00101;
    localparam logic [4:0] OP_SHRA = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_ROR  = 5'b01000;
    localparam logic [4:0] OP_ROL  = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_OR   = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LD_A = 3'd1,
        S_LD_B = 3'd2,
        S_EXEC = 3'd3,
        S_WB_LO = 3'd4,
        S_WB_HI = 3'd5,
        S_FIN = 3'd6
    } state_t;

    // MUL and DIV produce a 64-bit Z that is written back as LO then HI.
    function automatic logic is_wide(input logic [4:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR,
            OP_ROL, OP_MUL, OP_DIV, OP_NEG, OP_NOT, OP_LD, OP_LDI, OP_ST:
                return 1'b1;
            default:
                return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/seq_exec_counter.sv
// Loadable down-counter that times the ALU settle window; stops at zero.
module seq_exec_counter #(
    parameter int W = 4
) (
    input  logic         clock,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count;

    always_ff @(posedge clock) begin
        if (!clear) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle operand/result stage around the 32-bit ALU: loads A then B from the
// shared bus, waits EXEC_CYCLES for the ALU to settle, captures Z and writes it back.
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int EXEC_CYCLES = 1,
    parameter int OPW = 5
) (
    input  logic            clock,
    input  logic            clear,
    input  logic            start,
    input  logic [OPW-1:0]  op,
    input  logic [31:0]     bus_in,
    output logic [OPW-1:0]  alu_ops,
    output logic [31:0]     alu_a,
    output logic [31:0]     alu_b,
    input  logic [63:0]     zregin,
    output logic [31:0]     wb_data,
    output logic            wb_hi,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            busy,
    output logic            done,
    output logic            illegal
);

    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYCLES - 1);

    state_t         state;
    logic [OPW-1:0] op_q;
    logic [31:0]    y_q;
    logic [31:0]    b_q;
    logic [63:0]    z_q;
    logic           cnt_load;
    logic           cnt_dec;
    logic           cnt_zero;

    assign cnt_load = (state == S_LD_B);
    assign cnt_dec  = (state == S_EXEC) && !cnt_zero;

    seq_exec_counter #(.W(4)) u_cnt (
        .clock (clock),
        .clear (clear),
        .load  (cnt_load),
        .value (EXEC_LOAD),
        .dec   (cnt_dec),
        .zero  (cnt_zero)
    );

    assign alu_ops = op_q;
    assign alu_a   = y_q;
    assign alu_b   = b_q;
    // Z only changes on capture, so the selected half is stable through a stall.
    assign wb_data = wb_hi ? z_q[63:32] : z_q[31:0];

    always_ff @(posedge clock) begin
        if (!clear) begin
            state    <= S_IDLE;
            op_q     <= '0;
            y_q      <= '0;
            b_q      <= '0;
            z_q      <= '0;
            wb_hi    <= 1'b0;
            wb_valid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            done    <= 1'b0;
            illegal <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (is_legal(op)) begin
                            op_q  <= op;
                            busy  <= 1'b1;
                            state <= S_LD_A;
                        end else begin
                            illegal <= 1'b1;
                        end
                    end
                end
                S_LD_A: begin
                    y_q   <= bus_in;
                    state <= S_LD_B;
                end
                S_LD_B: begin
                    b_q   <= bus_in;
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (cnt_zero) begin
                        z_q      <= zregin;
                        wb_hi    <= 1'b0;
                        wb_valid <= 1'b1;
                        state    <= S_WB_LO;
                    end
                end
                S_WB_LO: begin
                    if (wb_ready) begin
                        if (is_wide(op_q)) begin
                            wb_hi <= 1'b1;
                            state <= S_WB_HI;
                        end else begin
                            wb_valid <= 1'b0;
                            done     <= 1'b1;
                            state    <= S_FIN;
                        end
                    end
                end
                S_WB_HI: begin
                    if (wb_ready) begin
                        wb_valid <= 1'b0;
                        wb_hi    <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_FIN;
                    end
                end
                S_FIN: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
